// File: rtl/ahb_slave_port_arbiter.sv
// Per-slave-port AHB arbiter: round-robin choice of the master that owns this slave's
// address phase, held across fixed/undefined bursts and locked sequences.
module ahb_slave_port_arbiter #(
    parameter int CHANNEL_NUM = 3,
    parameter int MID_W       = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1
) (
    input  logic                     HCLK,
    input  logic                     HRESET,
    input  logic [CHANNEL_NUM-1:0]   hsel_in,
    input  logic [2*CHANNEL_NUM-1:0] htrans_in,
    input  logic [3*CHANNEL_NUM-1:0] hburst_in,
    input  logic [CHANNEL_NUM-1:0]   hmastlock_in,
    input  logic                     hready_in,
    output logic [CHANNEL_NUM-1:0]   sel,
    output logic [MID_W-1:0]         hmaster_out,
    output logic [CHANNEL_NUM-1:0]   hready_out
);

    typedef enum logic {ST_IDLE, ST_OWNED} state_t;

    state_t                 state, state_next;
    logic [CHANNEL_NUM-1:0] sel_next;
    logic [MID_W-1:0]       rr_ptr, rr_ptr_next;
    logic [3:0]             beats_left, beats_left_next;
    logic                   undef_len, undef_len_next;
    logic                   burst_done, burst_done_next;

    logic [CHANNEL_NUM-1:0] req, cand;
    logic [MID_W-1:0]       owner, winner, rr_after_win;
    logic                   win_valid;
    logic [1:0]             own_trans;
    logic [2:0]             own_burst;
    logic                   own_hsel, own_lock;
    logic                   is_idle, is_busy, is_nonseq, is_seq;
    logic                   rel_cond, release_now;

    always_comb begin
        req        = '0;
        hready_out = '0;
        owner      = '0;
        own_trans  = 2'b00;
        own_burst  = 3'b000;
        own_hsel   = 1'b0;
        own_lock   = 1'b0;
        for (int i = 0; i < CHANNEL_NUM; i++) begin
            req[i]        = hsel_in[i] & htrans_in[2*i+1];
            hready_out[i] = sel[i] ? hready_in : ~req[i];
            if (sel[i]) begin
                owner     = MID_W'(i);
                own_trans = htrans_in[2*i +: 2];
                own_burst = hburst_in[3*i +: 3];
                own_hsel  = hsel_in[i];
                own_lock  = hmastlock_in[i];
            end
        end
    end

    assign hmaster_out = owner;

    // The owner's beat is consumed on the edge it releases, so it never competes for that edge.
    assign cand = req & ~sel;

    always_comb begin
        win_valid = 1'b0;
        winner    = '0;
        for (int k = 0; k < CHANNEL_NUM; k++) begin
            if (!win_valid && cand[(int'(rr_ptr) + k) % CHANNEL_NUM]) begin
                win_valid = 1'b1;
                winner    = MID_W'((int'(rr_ptr) + k) % CHANNEL_NUM);
            end
        end
        rr_after_win = (int'(winner) + 1 >= CHANNEL_NUM) ? '0 : MID_W'(int'(winner) + 1);
    end

    assign is_idle   = ~own_hsel | (own_trans == 2'b00);
    assign is_busy   = own_hsel & (own_trans == 2'b01);
    assign is_nonseq = own_hsel & (own_trans == 2'b10);
    assign is_seq    = own_hsel & (own_trans == 2'b11);

    // burst_done marks a burst that finished under lock, so a later unlocked NONSEQ may release.
    assign rel_cond = is_idle
                    | (is_nonseq & ((own_burst == 3'b000) | burst_done))
                    | (is_seq & ~undef_len & (beats_left == 4'd1))
                    | (undef_len & ~(is_seq | is_busy));
    assign release_now = (state == ST_OWNED) & hready_in & ~own_lock & rel_cond;

    always_comb begin
        state_next      = state;
        sel_next        = sel;
        rr_ptr_next     = rr_ptr;
        beats_left_next = beats_left;
        undef_len_next  = undef_len;
        burst_done_next = burst_done;
        if (state == ST_IDLE || release_now) begin
            beats_left_next = 4'd0;
            undef_len_next  = 1'b0;
            burst_done_next = 1'b0;
            if (win_valid) begin
                state_next  = ST_OWNED;
                sel_next    = CHANNEL_NUM'(1) << winner;
                rr_ptr_next = rr_after_win;
            end else begin
                state_next = ST_IDLE;
                sel_next   = '0;
            end
        end else if (hready_in) begin
            if (is_nonseq) begin
                undef_len_next  = (own_burst == 3'b001);
                burst_done_next = (own_burst == 3'b000);
                case (own_burst[2:1])
                    2'b00:   beats_left_next = 4'd0;
                    2'b01:   beats_left_next = 4'd3;
                    2'b10:   beats_left_next = 4'd7;
                    default: beats_left_next = 4'd15;
                endcase
            end else if (is_seq) begin
                if (!undef_len && beats_left != 4'd0) begin
                    beats_left_next = beats_left - 4'd1;
                    burst_done_next = (beats_left == 4'd1);
                end
            end else if (is_idle && undef_len) begin
                undef_len_next  = 1'b0;
                burst_done_next = 1'b1;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state      <= ST_IDLE;
            sel        <= '0;
            rr_ptr     <= '0;
            beats_left <= 4'd0;
            undef_len  <= 1'b0;
            burst_done <= 1'b0;
        end else begin
            state      <= state_next;
            sel        <= sel_next;
            rr_ptr     <= rr_ptr_next;
            beats_left <= beats_left_next;
            undef_len  <= undef_len_next;
            burst_done <= burst_done_next;
        end
    end

endmodule

// File: tb/tb_ahb_slave_port_arbiter.sv
// Scoreboard bench for ahb_slave_port_arbiter with three masters: each driven cycle queues the
// grant expected after the next edge, which is popped and checked once that edge has passed.
module tb_ahb_slave_port_arbiter;

    localparam logic [1:0] TI = 2'b00, TB = 2'b01, TN = 2'b10, TS = 2'b11;
    localparam logic [2:0] SGL = 3'b000, INC = 3'b001, I4 = 3'b011, W8 = 3'b100;

    logic       HCLK = 1'b0;
    logic       HRESET = 1'b1;
    logic [2:0] hsel_in = '0;
    logic [5:0] htrans_in = '0;
    logic [8:0] hburst_in = '0;
    logic [2:0] hmastlock_in = '0;
    logic       hready_in = 1'b1;
    logic [2:0] sel;
    logic [1:0] hmaster_out;
    logic [2:0] hready_out;

    logic [2:0] exp_q[$];
    int         n_checks = 0;
    int         n_fail = 0;

    ahb_slave_port_arbiter #(.CHANNEL_NUM(3)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .hsel_in(hsel_in), .htrans_in(htrans_in),
        .hburst_in(hburst_in), .hmastlock_in(hmastlock_in), .hready_in(hready_in),
        .sel(sel), .hmaster_out(hmaster_out), .hready_out(hready_out)
    );

    always #5 HCLK = ~HCLK;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic [2:0] hs, input logic [5:0] ht,
                                 input logic [8:0] hb, input logic [2:0] lk, input logic hr,
                                 input logic [2:0] exp_sel);
        logic [2:0] e;
        logic [2:0] r;
        logic [2:0] exp_rdy;
        logic [1:0] exp_mst;
        @(negedge HCLK);
        HRESET = rst; hsel_in = hs; htrans_in = ht; hburst_in = hb;
        hmastlock_in = lk; hready_in = hr;
        exp_q.push_back(exp_sel);
        @(posedge HCLK);
        #1;
        e = exp_q.pop_front();
        r = hs & {ht[5], ht[3], ht[1]};
        for (int i = 0; i < 3; i++) exp_rdy[i] = e[i] ? hr : ~r[i];
        exp_mst = e[2] ? 2'd2 : (e[1] ? 2'd1 : 2'd0);
        checkOutput("sel", 32'(sel), 32'(e));
        checkOutput("hmaster_out", 32'(hmaster_out), 32'(exp_mst));
        checkOutput("hready_out", 32'(hready_out), 32'(exp_rdy));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset held with all three requesting, then round robin over SINGLE beats
        applyStimulus(1, 3'b111, {TN,TN,TN}, {SGL,SGL,SGL}, 3'b000, 1, 3'b000);
        applyStimulus(1, 3'b111, {TN,TN,TN}, {SGL,SGL,SGL}, 3'b000, 1, 3'b000);
        applyStimulus(0, 3'b111, {TN,TN,TN}, {SGL,SGL,SGL}, 3'b000, 1, 3'b001);
        applyStimulus(0, 3'b111, {TN,TN,TN}, {SGL,SGL,SGL}, 3'b000, 1, 3'b010);
        applyStimulus(0, 3'b111, {TN,TN,TN}, {SGL,SGL,SGL}, 3'b000, 1, 3'b100);
        applyStimulus(0, 3'b111, {TN,TN,TN}, {SGL,SGL,SGL}, 3'b000, 1, 3'b001);
        applyStimulus(0, 3'b000, {TI,TI,TI}, {SGL,SGL,SGL}, 3'b000, 1, 3'b000);
        applyStimulus(0, 3'b000, {TI,TI,TI}, {SGL,SGL,SGL}, 3'b000, 1, 3'b000);

        // INCR4 from master 1 with wait states, master 0 waiting
        applyStimulus(0, 3'b011, {TI,TN,TN}, {SGL,I4,SGL}, 3'b000, 1, 3'b010);
        applyStimulus(0, 3'b011, {TI,TN,TN}, {SGL,I4,SGL}, 3'b000, 1, 3'b010);
        applyStimulus(0, 3'b011, {TI,TS,TN}, {SGL,I4,SGL}, 3'b000, 1, 3'b010);
        applyStimulus(0, 3'b011, {TI,TS,TN}, {SGL,I4,SGL}, 3'b000, 0, 3'b010);
        applyStimulus(0, 3'b011, {TI,TS,TN}, {SGL,I4,SGL}, 3'b000, 0, 3'b010);
        applyStimulus(0, 3'b011, {TI,TS,TN}, {SGL,I4,SGL}, 3'b000, 1, 3'b010);
        applyStimulus(0, 3'b011, {TI,TS,TN}, {SGL,I4,SGL}, 3'b000, 1, 3'b001);
        applyStimulus(0, 3'b001, {TI,TI,TN}, {SGL,SGL,SGL}, 3'b000, 1, 3'b000);
        applyStimulus(0, 3'b000, {TI,TI,TI}, {SGL,SGL,SGL}, 3'b000, 1, 3'b000);

        // Master 2 locked across two INCR4 bursts, lock drops during the second
        applyStimulus(0, 3'b100, {TN,TI,TI}, {I4,SGL,SGL}, 3'b100, 1, 3'b100);
        applyStimulus(0, 3'b111, {TN,TN,TN}, {I4,SGL,SGL}, 3'b100, 1, 3'b100);
        applyStimulus(0, 3'b111, {TS,TN,TN}, {I4,SGL,SGL}, 3'b100, 1, 3'b100);
        applyStimulus(0, 3'b111, {TS,TN,TN}, {I4,SGL,SGL}, 3'b100, 1, 3'b100);
        applyStimulus(0, 3'b111, {TS,TN,TN}, {I4,SGL,SGL}, 3'b100, 1, 3'b100);
        applyStimulus(0, 3'b111, {TN,TN,TN}, {I4,SGL,SGL}, 3'b100, 1, 3'b100);
        applyStimulus(0, 3'b111, {TS,TN,TN}, {I4,SGL,SGL}, 3'b100, 1, 3'b100);
        applyStimulus(0, 3'b111, {TS,TN,TN}, {I4,SGL,SGL}, 3'b000, 1, 3'b100);
        applyStimulus(0, 3'b111, {TS,TN,TN}, {I4,SGL,SGL}, 3'b000, 1, 3'b001);
        applyStimulus(0, 3'b011, {TI,TN,TN}, {SGL,SGL,SGL}, 3'b000, 1, 3'b010);
        applyStimulus(0, 3'b010, {TI,TN,TI}, {SGL,SGL,SGL}, 3'b000, 1, 3'b000);
        applyStimulus(0, 3'b000, {TI,TI,TI}, {SGL,SGL,SGL}, 3'b000, 1, 3'b000);

        // Undefined-length INCR from master 0: NONSEQ, six SEQ with one BUSY, then IDLE
        applyStimulus(0, 3'b001, {TI,TI,TN}, {SGL,SGL,INC}, 3'b000, 1, 3'b001);
        applyStimulus(0, 3'b001, {TI,TI,TN}, {SGL,SGL,INC}, 3'b000, 1, 3'b001);
        for (int i = 0; i < 3; i++)
            applyStimulus(0, 3'b001, {TI,TI,TS}, {SGL,SGL,INC}, 3'b000, 1, 3'b001);
        applyStimulus(0, 3'b001, {TI,TI,TB}, {SGL,SGL,INC}, 3'b000, 1, 3'b001);
        for (int i = 0; i < 3; i++)
            applyStimulus(0, 3'b001, {TI,TI,TS}, {SGL,SGL,INC}, 3'b000, 1, 3'b001);
        applyStimulus(0, 3'b000, {TI,TI,TI}, {SGL,SGL,SGL}, 3'b000, 1, 3'b000);

        // Reset in the middle of a WRAP8, then a grant taken while hready_in is low
        applyStimulus(0, 3'b010, {TI,TN,TI}, {SGL,W8,SGL}, 3'b000, 1, 3'b010);
        applyStimulus(0, 3'b010, {TI,TN,TI}, {SGL,W8,SGL}, 3'b000, 1, 3'b010);
        applyStimulus(0, 3'b010, {TI,TS,TI}, {SGL,W8,SGL}, 3'b000, 1, 3'b010);
        applyStimulus(0, 3'b010, {TI,TS,TI}, {SGL,W8,SGL}, 3'b000, 1, 3'b010);
        applyStimulus(1, 3'b010, {TI,TS,TI}, {SGL,W8,SGL}, 3'b000, 1, 3'b000);
        applyStimulus(0, 3'b010, {TI,TN,TI}, {SGL,SGL,SGL}, 3'b000, 0, 3'b010);
        applyStimulus(0, 3'b010, {TI,TN,TI}, {SGL,SGL,SGL}, 3'b000, 1, 3'b000);
        applyStimulus(0, 3'b000, {TI,TI,TI}, {SGL,SGL,SGL}, 3'b000, 1, 3'b000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
